syscall_checker: RTL and testbench
==================================

Name: syscall_checker

Overview:
Synthesizable, parametrised self-check block for CPU bring-up runs. It holds a table of expected values and, on each rising edge of the CPU's syscall interrupt, compares the probed register or memory word against the next table entry. It counts mismatches, captures the first failure, enforces a cycle timeout, and flags extra interrupts. It sits beside the cpu instance, on its regTest/memTest probe outputs, so pass/fail can be read on hardware or by a thin bench.

Parameters:
DATA_WIDTH, 32, width of probed values and expected entries
NUM_CHECKS, 12, number of expected-value entries (>=1)
TIMEOUT_CYCLES, 10000, RUN cycles allowed before timeout (>=1)
CNT_WIDTH, 8, width of the fail counter (saturating)
IDX_WIDTH, $clog2(NUM_CHECKS) with a minimum of 1, width of the table index (derived)

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
exp_we  in  1  expected-table write strobe
exp_addr  in  IDX_WIDTH  table write index
exp_data  in  DATA_WIDTH  expected value to write
exp_src  in  1  source for this entry: 0 = reg_value, 1 = mem_value
exp_mask  in  DATA_WIDTH  compare mask for this entry (1 = bit compared)
start  in  1  begin a run (pulse)
interrupt  in  1  cpu syscall interrupt (level; rising edge = check request)
reg_value  in  DATA_WIDTH  cpu register probe
mem_value  in  DATA_WIDTH  cpu memory probe
busy  out  1  high in RUN
done  out  1  high in DONE
passed  out  1  valid when done
timed_out  out  1  run ended by timeout
overrun  out  1  interrupt edge seen in DONE
check_idx  out  IDX_WIDTH+1  checks completed this run
fail_count  out  CNT_WIDTH  mismatches this run (saturating)
first_fail_idx  out  IDX_WIDTH  index of first mismatch
first_fail_value  out  DATA_WIDTH  probed value at first mismatch

Behaviour:
- Reset value of every output and state register is 0. State goes to IDLE; int_q = 0. Table contents are not reset.
- States:
  - IDLE: start -> RUN.
  - RUN: ends in DONE by completion or timeout.
  - DONE: start -> RUN (restart).
- Entering RUN clears check_idx, fail_count, first_fail_*, timed_out, overrun, passed and the timeout counter.
- start while in RUN is ignored.
- Table writes (exp_data, exp_src, exp_mask stored at exp_addr) are accepted only in IDLE or DONE. They are silently ignored in RUN. An exp_addr >= NUM_CHECKS is ignored.
- Edge detect: int_q <= interrupt every cycle. edge = interrupt & ~int_q. A level held high counts once.
- On edge in RUN:
  - sel = exp_src[check_idx] ? mem_value : reg_value, sampled in the edge cycle.
  - mismatch = ((sel ^ exp_data[check_idx]) & exp_mask[check_idx]) != 0.
  - On mismatch: fail_count increments, saturating at all-ones. If it is the first mismatch, first_fail_idx and first_fail_value are captured.
  - check_idx increments.
  - Results are visible the cycle after the edge (1-cycle latency).
- Completion: the edge that makes check_idx == NUM_CHECKS moves to DONE in the same update.
- Timeout: the counter increments every RUN cycle. When it reaches TIMEOUT_CYCLES-1 without completion, the block goes to DONE with timed_out = 1.
- Edge and timeout in the same cycle: the edge is processed first. If it completes the table, timed_out stays 0. Otherwise timed_out = 1 and the edge's compare is still recorded.
- In DONE, any edge sets overrun = 1 (sticky until the next start) and forces passed = 0. No compare is made.
- passed = (fail_count == 0) & ~timed_out & ~overrun, registered on entry to DONE and updated on overrun.
- Reset mid-run: the run is abandoned, outputs return to 0, state goes to IDLE, table is retained.
- Edge in IDLE is ignored; only int_q tracks.

Decomposition:
- Shared package (cpu_test_pkg): state encoding (IDLE/RUN/DONE), source-select constants SRC_REG = 0 and SRC_MEM = 1.
- One sub-module: rise_detect (1-bit registered rising-edge detector with synchronous reset), reused for start qualification elsewhere.
- Expected table: plain register arrays inside syscall_checker.

Test Plan:
- Load 12 entries (15, 20, 25, 30, 35, 40, 45, 9, 27, 3, 1, 0), all SRC_REG with full mask. Start, then 12 interrupt pulses with matching reg_value -> done = 1, passed = 1, fail_count = 0, check_idx = 12.
- Same table, reg_value = 26 on check 2 and 7 on check 9 -> fail_count = 2, first_fail_idx = 2, first_fail_value = 26, passed = 0.
- Entry 0 uses SRC_MEM, expected 0xABCD, mask 0x0000FFFF. mem_value = 0x1234ABCD and reg_value = 0 -> no mismatch.
- TIMEOUT_CYCLES = 50, only 5 pulses -> done at RUN cycle 50, timed_out = 1, check_idx = 5, passed = 0.
- After a passing run, one extra pulse -> overrun = 1, passed = 0. Then start -> overrun = 0, busy = 1.
- Assert reset after check 6 -> all outputs 0, state IDLE. Start again with no reloading -> table intact and a full pass is reached.
- Hold interrupt high for 20 cycles -> check_idx advances by exactly 1.

Source files
------------

// File: rtl/cpu_test_pkg.sv
// Shared definitions for the CPU bring-up self-check logic:
// checker state encoding, table source selects and a width helper.
package cpu_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic SRC_REG = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    // Index/counter width for n distinct values, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/syscall_checker_rise_detect.sv
// One-bit registered rising-edge detector with synchronous reset.
// The output is combinational: high in the cycle the input first goes high.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic d_d;

    always_comb begin
        d_d = d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/syscall_checker.sv
// Bring-up self-check: compares CPU probe values against a table of expected
// entries on each syscall interrupt edge, with timeout and overrun detection.
module syscall_checker
    import cpu_test_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int NUM_CHECKS     = 12,
    parameter  int TIMEOUT_CYCLES = 10000,
    parameter  int CNT_WIDTH      = 8,
    localparam int IDX_WIDTH      = idx_width(NUM_CHECKS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  exp_we,
    input  logic [IDX_WIDTH-1:0]  exp_addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic                  exp_src,
    input  logic [DATA_WIDTH-1:0] exp_mask,
    input  logic                  start,
    input  logic                  interrupt,
    input  logic [DATA_WIDTH-1:0] reg_value,
    input  logic [DATA_WIDTH-1:0] mem_value,
    output logic                  busy,
    output logic                  done,
    output logic                  passed,
    output logic                  timed_out,
    output logic                  overrun,
    output logic [IDX_WIDTH:0]    check_idx,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic [IDX_WIDTH-1:0]  first_fail_idx,
    output logic [DATA_WIDTH-1:0] first_fail_value
);

    localparam int TMO_WIDTH = idx_width(TIMEOUT_CYCLES);

    localparam logic [IDX_WIDTH:0]   IDX_ONE  = (IDX_WIDTH+1)'(1);
    localparam logic [IDX_WIDTH:0]   IDX_LAST = (IDX_WIDTH+1)'(NUM_CHECKS - 1);
    localparam logic [IDX_WIDTH:0]   IDX_NUM  = (IDX_WIDTH+1)'(NUM_CHECKS);
    localparam logic [TMO_WIDTH-1:0] TMO_ONE  = TMO_WIDTH'(1);
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] exp_data_q [NUM_CHECKS];
    logic [DATA_WIDTH-1:0] exp_mask_q [NUM_CHECKS];
    logic                  exp_src_q  [NUM_CHECKS];

    state_e                state_q,            state_d;
    logic [IDX_WIDTH:0]    check_idx_q,        check_idx_d;
    logic [CNT_WIDTH-1:0]  fail_count_q,       fail_count_d;
    logic [IDX_WIDTH-1:0]  first_fail_idx_q,   first_fail_idx_d;
    logic [DATA_WIDTH-1:0] first_fail_value_q, first_fail_value_d;
    logic                  timed_out_q,        timed_out_d;
    logic                  overrun_q,          overrun_d;
    logic                  passed_q,           passed_d;
    logic [TMO_WIDTH-1:0]  tmo_cnt_q,          tmo_cnt_d;

    logic                  irq_edge;
    logic                  tbl_we;
    logic                  enter_run;
    logic                  mismatch;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [DATA_WIDTH-1:0] sel_value;

    rise_detect u_irq_rise (
        .clk   (clk),
        .reset (reset),
        .d     (interrupt),
        .rise  (irq_edge)
    );

    // The table is frozen for the duration of a run so entries cannot shift under a check.
    always_comb begin
        tbl_we = exp_we && (state_q != ST_RUN) && ({1'b0, exp_addr} < IDX_NUM);
    end

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            exp_data_q[exp_addr] <= exp_data;
            exp_mask_q[exp_addr] <= exp_mask;
            exp_src_q[exp_addr]  <= exp_src;
        end
    end

    always_comb begin
        rd_idx    = check_idx_q[IDX_WIDTH-1:0];
        sel_value = (exp_src_q[rd_idx] == SRC_MEM) ? mem_value : reg_value;
        mismatch  = |((sel_value ^ exp_data_q[rd_idx]) & exp_mask_q[rd_idx]);
    end

    always_comb begin
        state_d            = state_q;
        check_idx_d        = check_idx_q;
        fail_count_d       = fail_count_q;
        first_fail_idx_d   = first_fail_idx_q;
        first_fail_value_d = first_fail_value_q;
        timed_out_d        = timed_out_q;
        overrun_d          = overrun_q;
        passed_d           = passed_q;
        tmo_cnt_d          = tmo_cnt_q;
        enter_run          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                enter_run = start;
            end
            ST_RUN: begin
                if (irq_edge) begin
                    if (mismatch) begin
                        if (fail_count_q == '0) begin
                            first_fail_idx_d   = rd_idx;
                            first_fail_value_d = sel_value;
                        end
                        if (fail_count_q != '1) begin
                            fail_count_d = fail_count_q + CNT_ONE;
                        end
                    end
                    check_idx_d = check_idx_q + IDX_ONE;
                end
                // A completing edge wins over a timeout landing in the same cycle.
                if (irq_edge && (check_idx_q == IDX_LAST)) begin
                    state_d = ST_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = ST_DONE;
                    timed_out_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                end
                if (state_d == ST_DONE) begin
                    passed_d = (fail_count_d == '0) && !timed_out_d && !overrun_q;
                end
            end
            ST_DONE: begin
                if (start) begin
                    enter_run = 1'b1;
                end else if (irq_edge) begin
                    overrun_d = 1'b1;
                    passed_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_run) begin
            state_d            = ST_RUN;
            check_idx_d        = '0;
            fail_count_d       = '0;
            first_fail_idx_d   = '0;
            first_fail_value_d = '0;
            timed_out_d        = 1'b0;
            overrun_d          = 1'b0;
            passed_d           = 1'b0;
            tmo_cnt_d          = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            check_idx_q        <= '0;
            fail_count_q       <= '0;
            first_fail_idx_q   <= '0;
            first_fail_value_q <= '0;
            timed_out_q        <= 1'b0;
            overrun_q          <= 1'b0;
            passed_q           <= 1'b0;
            tmo_cnt_q          <= '0;
        end else begin
            state_q            <= state_d;
            check_idx_q        <= check_idx_d;
            fail_count_q       <= fail_count_d;
            first_fail_idx_q   <= first_fail_idx_d;
            first_fail_value_q <= first_fail_value_d;
            timed_out_q        <= timed_out_d;
            overrun_q          <= overrun_d;
            passed_q           <= passed_d;
            tmo_cnt_q          <= tmo_cnt_d;
        end
    end

    assign busy             = (state_q == ST_RUN);
    assign done             = (state_q == ST_DONE);
    assign passed           = passed_q;
    assign timed_out        = timed_out_q;
    assign overrun          = overrun_q;
    assign check_idx        = check_idx_q;
    assign fail_count       = fail_count_q;
    assign first_fail_idx   = first_fail_idx_q;
    assign first_fail_value = first_fail_value_q;

endmodule

// File: tb/tb_syscall_checker.sv
// Directed scoreboard bench for syscall_checker: a bench-side model of the
// expected table predicts every compare result, which is queued and checked.
module tb_syscall_checker;

    localparam int DW = 32;
    localparam int NC = 12;
    localparam int TO = 50;
    localparam int CW = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          exp_we = 1'b0;
    logic [IW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_data = '0;
    logic          exp_src = 1'b0;
    logic [DW-1:0] exp_mask = '0;
    logic          start = 1'b0;
    logic          interrupt = 1'b0;
    logic [DW-1:0] reg_value = '0;
    logic [DW-1:0] mem_value = '0;
    logic          busy, done, passed, timed_out, overrun;
    logic [IW:0]   check_idx;
    logic [CW-1:0] fail_count;
    logic [IW-1:0] first_fail_idx;
    logic [DW-1:0] first_fail_value;

    typedef struct packed {
        logic [IW:0]   idx;
        logic [CW-1:0] fail;
        logic [IW-1:0] ffi;
        logic [DW-1:0] ffv;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] m_data [NC];
    logic [DW-1:0] m_mask [NC];
    logic          m_src  [NC];
    int            m_idx;
    logic [CW-1:0] m_fail;
    logic [IW-1:0] m_ffi;
    logic [DW-1:0] m_ffv;
    int            checks = 0;
    int            errors = 0;
    time           t0, t1;

    syscall_checker #(
        .DATA_WIDTH     (DW),
        .NUM_CHECKS     (NC),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .exp_we           (exp_we),
        .exp_addr         (exp_addr),
        .exp_data         (exp_data),
        .exp_src          (exp_src),
        .exp_mask         (exp_mask),
        .start            (start),
        .interrupt        (interrupt),
        .reg_value        (reg_value),
        .mem_value        (mem_value),
        .busy             (busy),
        .done             (done),
        .passed           (passed),
        .timed_out        (timed_out),
        .overrun          (overrun),
        .check_idx        (check_idx),
        .fail_count       (fail_count),
        .first_fail_idx   (first_fail_idx),
        .first_fail_value (first_fail_value)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic writeEntry(input int addr, input logic [DW-1:0] data, input logic src,
                              input logic [DW-1:0] mask, input bit accepted);
        exp_we   = 1'b1;
        exp_addr = IW'(addr);
        exp_data = data;
        exp_src  = src;
        exp_mask = mask;
        @(negedge clk);
        exp_we = 1'b0;
        if (accepted && addr < NC) begin
            m_data[addr] = data;
            m_src[addr]  = src;
            m_mask[addr] = mask;
        end
        @(negedge clk);
    endtask

    task automatic startRun();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0     = $time;
        m_idx  = 0;
        m_fail = '0;
        m_ffi  = '0;
        m_ffv  = '0;
    endtask

    // Predict the compare for the current model entry, queue it, pulse the interrupt, check.
    task automatic applyStimulus(input logic [DW-1:0] regv, input logic [DW-1:0] memv);
        logic [DW-1:0] sel;
        exp_t          e;
        exp_t          got;
        sel = m_src[m_idx] ? memv : regv;
        if (((sel ^ m_data[m_idx]) & m_mask[m_idx]) != '0) begin
            if (m_fail == '0) begin
                m_ffi = IW'(m_idx);
                m_ffv = sel;
            end
            if (m_fail != '1) m_fail = m_fail + 8'd1;
        end
        m_idx++;
        e.idx  = (IW+1)'(m_idx);
        e.fail = m_fail;
        e.ffi  = m_ffi;
        e.ffv  = m_ffv;
        sbq.push_back(e);
        reg_value = regv;
        mem_value = memv;
        interrupt = 1'b1;
        @(negedge clk);
        interrupt = 1'b0;
        got = sbq.pop_front();
        checkOutput("check_idx", 64'(check_idx), 64'(got.idx));
        checkOutput("fail_count", 64'(fail_count), 64'(got.fail));
        checkOutput("first_fail_idx", 64'(first_fail_idx), 64'(got.ffi));
        checkOutput("first_fail_value", 64'(first_fail_value), 64'(got.ffv));
        @(negedge clk);
    endtask

    task automatic matchingPulses(input int n);
        for (int i = 0; i < n; i++) applyStimulus(m_data[m_idx], m_data[m_idx]);
    endtask

    task automatic checkDone(input string tag, input logic exp_passed, input logic exp_to, input int exp_idx);
        checkOutput({tag, "_done"}, 64'(done), 64'(1));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
        checkOutput({tag, "_passed"}, 64'(passed), 64'(exp_passed));
        checkOutput({tag, "_timed_out"}, 64'(timed_out), 64'(exp_to));
        checkOutput({tag, "_check_idx"}, 64'(check_idx), 64'(exp_idx));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_outputs"},
                    64'({busy, done, passed, timed_out, overrun, check_idx, fail_count, first_fail_idx}), 64'(0));
        checkOutput({tag, "_ffv"}, 64'(first_fail_value), 64'(0));
    endtask

    initial begin
        int init_vals [NC] = '{15, 20, 25, 30, 35, 40, 45, 9, 27, 3, 1, 0};
        int waited;

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkAllZero("reset");

        for (int i = 0; i < NC; i++) writeEntry(i, DW'(init_vals[i]), 1'b0, '1, 1'b1);
        writeEntry(13, 32'hDEAD, 1'b1, '1, 1'b1);

        $display("[TB] full matching run");
        startRun();
        checkOutput("a_busy", 64'(busy), 64'(1));
        matchingPulses(NC);
        checkDone("a", 1'b1, 1'b0, NC);

        $display("[TB] overrun after completion");
        interrupt = 1'b1;
        @(negedge clk);
        interrupt = 1'b0;
        checkOutput("ovr_overrun", 64'(overrun), 64'(1));
        checkOutput("ovr_passed", 64'(passed), 64'(0));
        checkOutput("ovr_check_idx", 64'(check_idx), 64'(NC));
        @(negedge clk);
        startRun();
        checkOutput("restart_overrun", 64'(overrun), 64'(0));
        checkOutput("restart_busy", 64'(busy), 64'(1));
        checkOutput("restart_check_idx", 64'(check_idx), 64'(0));

        $display("[TB] two mismatches, write during run ignored");
        writeEntry(5, 32'd999, 1'b0, '1, 1'b0);
        for (int i = 0; i < NC; i++) begin
            if (i == 2) applyStimulus(32'd26, 32'd0);
            else if (i == 9) applyStimulus(32'd7, 32'd0);
            else applyStimulus(m_data[i], 32'd0);
        end
        checkDone("b", 1'b0, 1'b0, NC);
        checkOutput("b_fail_count", 64'(fail_count), 64'(2));
        checkOutput("b_first_fail_idx", 64'(first_fail_idx), 64'(2));
        checkOutput("b_first_fail_value", 64'(first_fail_value), 64'(26));

        $display("[TB] masked memory-source entry");
        writeEntry(0, 32'h0000ABCD, 1'b1, 32'h0000FFFF, 1'b1);
        startRun();
        applyStimulus(32'd0, 32'h1234ABCD);
        checkOutput("c_no_mismatch", 64'(fail_count), 64'(0));
        matchingPulses(NC - 1);
        checkDone("c", 1'b1, 1'b0, NC);

        $display("[TB] timeout after five checks");
        startRun();
        matchingPulses(5);
        waited = 0;
        while (!done && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        t1 = $time;
        checkOutput("to_within_bound", 64'(done), 64'(1));
        checkOutput("to_run_cycles", 64'((t1 - t0) / 10), 64'(TO));
        checkDone("to", 1'b0, 1'b1, 5);

        $display("[TB] level-held interrupt counts once");
        startRun();
        begin
            exp_t got;
            sbq.push_back('{idx: (IW+1)'(1), fail: '0, ffi: '0, ffv: '0});
            m_idx     = 1;
            reg_value = 32'd0;
            mem_value = m_data[0];
            interrupt = 1'b1;
            repeat (20) @(negedge clk);
            got = sbq.pop_front();
            checkOutput("hold_check_idx", 64'(check_idx), 64'(got.idx));
            checkOutput("hold_fail_count", 64'(fail_count), 64'(got.fail));
            checkOutput("hold_busy", 64'(busy), 64'(1));
            interrupt = 1'b0;
            @(negedge clk);
        end
        matchingPulses(5);

        $display("[TB] reset mid-run, table retained");
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("midreset");
        reset = 1'b0;
        @(negedge clk);
        checkAllZero("after_reset");
        startRun();
        matchingPulses(NC);
        checkDone("retained", 1'b1, 1'b0, NC);
        checkOutput("retained_fail_count", 64'(fail_count), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
